// File: rtl/wbs_bist_ctrl.sv
// Wishbone-controlled BIST engine: an LFSR drives test patterns into the logic under
// test and a MISR compacts the responses into a signature.
module wbs_bist_ctrl (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [31:0] bist_pat_o,
    output logic        bist_valid_o,
    input  logic [31:0] bist_resp_i,
    output logic        bist_done_o,
    output logic        bist_pass_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [15:0] pat_cnt_q, pat_cnt_d;
    logic [31:0] seed_q, seed_d;
    logic [31:0] exp_sig_q, exp_sig_d;
    logic [31:0] sig_q, sig_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] misr_q, misr_d;
    logic [31:0] last_pat_q, last_pat_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;

    logic        req, wr, rd, busy, apply, start_w, abort_w;
    logic [2:0]  adr;
    logic [31:0] seed_m, exp_m, lfsr_step, misr_step, rd_data;
    logic [15:0] pat_cnt_m;
    logic        unused_adr;

    assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    // A new transfer is only accepted when ack is low, so acks never occur back to back.
    assign req     = wbs_cyc_i && wbs_stb_i && !ack_q;
    assign wr      = req && wbs_we_i;
    assign rd      = req && !wbs_we_i;
    assign adr     = wbs_adr_i[4:2];
    assign start_w = wr && (adr == 3'd0) && wbs_dat_i[0];
    assign abort_w = wr && (adr == 3'd0) && wbs_dat_i[1];
    assign busy    = (state_q == S_RUN);
    assign apply   = busy && (cnt_q < pat_cnt_q);

    assign lfsr_step = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    assign misr_step = {misr_q[30:0], misr_q[31] ^ misr_q[21] ^ misr_q[1] ^ misr_q[0]} ^ bist_resp_i;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign seed_m[gi*8 +: 8] = wbs_sel_i[gi] ? wbs_dat_i[gi*8 +: 8] : seed_q[gi*8 +: 8];
            assign exp_m[gi*8 +: 8]  = wbs_sel_i[gi] ? wbs_dat_i[gi*8 +: 8] : exp_sig_q[gi*8 +: 8];
            if (gi < 2) begin : g_cnt
                assign pat_cnt_m[gi*8 +: 8] = wbs_sel_i[gi] ? wbs_dat_i[gi*8 +: 8]
                                                            : pat_cnt_q[gi*8 +: 8];
            end
        end
    endgenerate

    always_comb begin
        rd_data = 32'h0;
        case (adr)
            3'd1: rd_data = {16'h0, pat_cnt_q};
            3'd2: rd_data = seed_q;
            3'd3: rd_data = exp_sig_q;
            3'd4: rd_data = sig_q;
            3'd5: rd_data = {cnt_q, 12'h0, fail_q, pass_q, (state_q == S_DONE), busy};
            default: rd_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = req;
        dat_d      = rd ? rd_data : 32'h0;
        pat_cnt_d  = pat_cnt_q;
        seed_d     = seed_q;
        exp_sig_d  = exp_sig_q;
        sig_d      = sig_q;
        lfsr_d     = lfsr_q;
        misr_d     = misr_q;
        last_pat_d = last_pat_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        fail_d     = fail_q;

        if (wr && !busy) begin
            case (adr)
                3'd1:    pat_cnt_d = pat_cnt_m;
                3'd2:    seed_d    = seed_m;
                3'd3:    exp_sig_d = exp_m;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                // start together with abort counts as abort, which is a no-op here
                if (start_w && !abort_w) begin
                    state_d = S_RUN;
                    lfsr_d  = (seed_q == 32'h0) ? 32'h1 : seed_q;
                    misr_d  = 32'h0;
                    cnt_d   = 16'h0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (apply) begin
                    lfsr_d     = lfsr_step;
                    misr_d     = misr_step;
                    last_pat_d = lfsr_q;
                    cnt_d      = cnt_q + 16'd1;
                end
                // the pattern presented in the abort cycle is still compacted
                if (abort_w) begin
                    state_d = S_DONE;
                    sig_d   = apply ? misr_step : misr_q;
                    pass_d  = 1'b0;
                    fail_d  = 1'b1;
                end else if (!apply) begin
                    state_d = S_DONE;
                    sig_d   = misr_q;
                    pass_d  = (misr_q == exp_sig_q);
                    fail_d  = (misr_q != exp_sig_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
            pat_cnt_q  <= 16'h0;
            seed_q     <= 32'h0;
            exp_sig_q  <= 32'h0;
            sig_q      <= 32'h0;
            lfsr_q     <= 32'h0;
            misr_q     <= 32'h0;
            last_pat_q <= 32'h0;
            cnt_q      <= 16'h0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            pat_cnt_q  <= pat_cnt_d;
            seed_q     <= seed_d;
            exp_sig_q  <= exp_sig_d;
            sig_q      <= sig_d;
            lfsr_q     <= lfsr_d;
            misr_q     <= misr_d;
            last_pat_q <= last_pat_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign bist_valid_o = apply;
    assign bist_pat_o   = apply ? lfsr_q : last_pat_q;
    assign bist_done_o  = (state_q == S_DONE);
    assign bist_pass_o  = pass_q;

endmodule

// File: tb/tb_wbs_bist_ctrl.sv
// Directed and randomized checks of wbs_bist_ctrl against a pattern/signature model
// computed directly from the LFSR/MISR recurrences.
module tb_wbs_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w, dat_r;
    logic        ack;
    logic [31:0] pat, resp;
    logic        valid, done_o, pass_o;
    logic [31:0] resp_mask = 32'h0;
    logic [31:0] resp_key  = 32'h0;

    always #5 clk = ~clk;

    assign resp = (pat & resp_mask) ^ resp_key;

    wbs_bist_ctrl dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (dat_w),
        .wbs_dat_o    (dat_r),
        .wbs_ack_o    (ack),
        .bist_pat_o   (pat),
        .bist_valid_o (valid),
        .bist_resp_i  (resp),
        .bist_done_o  (done_o),
        .bist_pass_o  (pass_o)
    );

    logic [31:0] obs_pats[$];
    always @(negedge clk) if (valid) obs_pats.push_back(pat);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    function automatic logic [31:0] model_pat(input logic [31:0] seed, input int i);
        logic [31:0] v;
        v = (seed == 32'h0) ? 32'h1 : seed;
        for (int k = 0; k < i; k++) v = step(v);
        return v;
    endfunction

    function automatic logic [31:0] model_sig(input logic [31:0] seed, input int n,
                                              input logic [31:0] mask, input logic [31:0] key);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < n; i++) m = step(m) ^ ((model_pat(seed, i) & mask) ^ key);
        return m;
    endfunction

    // Callers are positioned #1 after a rising edge; the request is driven immediately.
    task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic got;
        got = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {27'h0, a, 2'b00}; dat_w = d; sel = s;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            got = ack;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("wb write adr=%0d data=0x%08h sel=%b ack=%0b", a, d, s, got);
        check("wr_ack", {31'h0, got}, 32'h1);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        logic got;
        got = 1'b0;
        d   = 32'hx;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {27'h0, a, 2'b00}; sel = 4'hf;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            got = ack;
            d   = dat_r;
        end
        cyc = 1'b0; stb = 1'b0;
        $display("wb read  adr=%0d data=0x%08h ack=%0b", a, d, got);
        check("rd_ack", {31'h0, got}, 32'h1);
    endtask

    task automatic wait_done(output logic [31:0] st);
        logic seen;
        seen = 1'b0;
        st   = 32'h0;
        for (int k = 0; k < 100 && !seen; k++) begin
            wb_read(3'd5, st);
            seen = st[1];
        end
        check("done_timeout", {31'h0, seen}, 32'h1);
    endtask

    task automatic do_run(input logic [31:0] seed, input logic [15:0] n,
                          input logic [31:0] mask, input logic [31:0] key,
                          input logic [31:0] expsig, input bit restart_mid,
                          output logic [31:0] sig_obs);
        logic [31:0] msig, st, rv;
        logic        exp_pass;
        resp_mask = mask;
        resp_key  = key;
        msig      = model_sig(seed, int'(n), mask, key);
        exp_pass  = (msig == expsig);
        wb_write(3'd1, {16'h0, n}, 4'hf);
        wb_write(3'd2, seed, 4'hf);
        wb_write(3'd3, expsig, 4'hf);
        obs_pats.delete();
        wb_write(3'd0, 32'h1, 4'hf);
        if (restart_mid) begin
            wb_write(3'd0, 32'h1, 4'hf);
            wb_write(3'd1, 32'hffff, 4'hf);
        end
        wait_done(st);
        $display("run seed=0x%08h n=%0d applied=%0d", seed, n, obs_pats.size());
        check("pat_count", obs_pats.size(), {16'h0, n});
        for (int i = 0; i < obs_pats.size() && i < int'(n); i++)
            check($sformatf("pat[%0d]", i), obs_pats[i], model_pat(seed, i));
        wb_read(3'd4, sig_obs);
        check("signature", sig_obs, msig);
        check("status", st, {n, 16'h0} | (exp_pass ? 32'h4 : 32'h8) | 32'h2);
        check("done_o", {31'h0, done_o}, 32'h1);
        check("pass_o", {31'h0, pass_o}, {31'h0, exp_pass});
        if (restart_mid) begin
            wb_read(3'd1, rv);
            check("patcnt_locked", rv, {16'h0, n});
        end
    endtask

    initial begin
        logic [31:0] rv, sig, st, st2, s0, seed, mask, key, expsig;
        logic [15:0] n;
        bit          exp_ack;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", dat_r, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_pat", pat, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_pass", {31'h0, pass_o}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int a = 0; a < 8; a++) begin
            wb_read(3'(a), rv);
            check($sformatf("rst_reg%0d", a), rv, 32'h0);
        end

        // byte-select merging and unmapped/CTRL read-back
        wb_write(3'd2, 32'hffff_ffff, 4'hf);
        wb_write(3'd2, 32'h1234_5678, 4'b0101);
        wb_read(3'd2, rv);
        check("sel_seed", rv, 32'hff34_ff78);
        wb_write(3'd1, 32'hdead_beef, 4'b0010);
        wb_read(3'd1, rv);
        check("sel_patcnt", rv, 32'h0000_be00);
        wb_write(3'd6, 32'h5555_aaaa, 4'hf);
        wb_read(3'd6, rv);
        check("unmapped6", rv, 32'h0);
        wb_read(3'd0, rv);
        check("ctrl_reads0", rv, 32'h0);

        // single-pattern loopback: pattern 1, signature 1, pass
        do_run(32'h1, 16'd1, 32'hffff_ffff, 32'h0, 32'h1, 1'b0, sig);
        check("r24_pat0", obs_pats.size() > 0 ? obs_pats[0] : 32'hx, 32'h1);
        check("r24_sig", sig, 32'h1);
        wb_read(3'd5, rv);
        check("r24_status", rv, 32'h0001_0006);

        // two patterns 1,3 cancel to signature 0 -> fail
        do_run(32'h1, 16'd2, 32'hffff_ffff, 32'h0, 32'h1, 1'b0, sig);
        check("r25_pat1", obs_pats.size() > 1 ? obs_pats[1] : 32'hx, 32'h3);
        check("r25_sig", sig, 32'h0);
        check("r25_pass_o", {31'h0, pass_o}, 32'h0);

        // zero seed substitutes 1; zero response
        do_run(32'h0, 16'd3, 32'h0, 32'h0, 32'h0, 1'b0, sig);
        check("r26_pat0", obs_pats.size() > 0 ? obs_pats[0] : 32'hx, 32'h1);
        check("r26_sig", sig, 32'h0);

        // zero patterns: straight to DONE with signature 0
        do_run($urandom, 16'd0, 32'hffff_ffff, 32'h0, 32'h5, 1'b0, sig);
        check("r11_sig", sig, 32'h0);

        // abort and start+abort in DONE are ignored
        wb_read(3'd5, st);
        wb_write(3'd0, 32'h2, 4'hf);
        wb_read(3'd5, st2);
        check("abort_in_done", st2, st);
        wb_write(3'd0, 32'h3, 4'hf);
        wb_read(3'd5, st2);
        check("startabort_in_done", st2, st);

        for (int r = 0; r < 6; r++) begin
            seed   = $urandom;
            n      = 16'($urandom_range(12, 40));
            mask   = $urandom;
            key    = $urandom;
            expsig = ($urandom_range(0, 1) == 1) ? model_sig(seed, int'(n), mask, key) : $urandom;
            do_run(seed, n, mask, key, expsig, 1'b1, sig);
        end

        // abort (with start also set) after 10 applied patterns; SEED write ignored mid-run
        s0 = $urandom; mask = $urandom; key = $urandom;
        resp_mask = mask; resp_key = key;
        wb_write(3'd1, 32'd100, 4'hf);
        wb_write(3'd2, s0, 4'hf);
        wb_write(3'd3, 32'h0, 4'hf);
        obs_pats.delete();
        wb_write(3'd0, 32'h1, 4'hf);
        wb_write(3'd2, ~s0, 4'hf);
        wb_read(3'd2, rv);
        check("r27_seed_locked", rv, s0);
        for (int k = 0; k < 50 && obs_pats.size() < 9; k++) begin
            @(posedge clk); #1;
        end
        wb_write(3'd0, 32'h3, 4'hf);
        check("r27_valid_off", {31'h0, valid}, 32'h0);
        wb_read(3'd5, st);
        check("r27_status", st, 32'h000a_000a);
        check("r27_applied", obs_pats.size(), 32'd10);
        wb_read(3'd4, sig);
        check("r27_sig", sig, model_sig(s0, 10, mask, key));

        // cyc/stb held: ack every other cycle, data only with ack
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {27'h0, 3'd2, 2'b00};
        for (int i = 0; i < 10; i++) begin
            if (i == 6) adr = {27'h0, 3'd7, 2'b00};
            @(posedge clk); #1;
            exp_ack = (i % 2 == 0);
            $display("wb held read cycle=%0d ack=%0b data=0x%08h", i, ack, dat_r);
            check($sformatf("b2b_ack%0d", i), {31'h0, ack}, {31'h0, exp_ack});
            check($sformatf("b2b_dat%0d", i), dat_r, (exp_ack && i < 6) ? s0 : 32'h0);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;

        // reset pulse mid-run
        wb_write(3'd1, 32'd50, 4'hf);
        wb_write(3'd0, 32'h1, 4'hf);
        repeat (5) @(posedge clk);
        #1;
        check("r29_running", {31'h0, valid}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("r29_valid", {31'h0, valid}, 32'h0);
        check("r29_pat", pat, 32'h0);
        check("r29_done", {31'h0, done_o}, 32'h0);
        check("r29_pass", {31'h0, pass_o}, 32'h0);
        for (int a = 1; a < 6; a++) begin
            wb_read(3'(a), rv);
            check($sformatf("r29_reg%0d", a), rv, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
